mat_skew_feeder: RTL and testbench

//  Upstream feeder for the systolic MatUnit array: buffers row vectors from the

---
 rtl/mat_skew_feeder.sv | 181 ++++++++++++++++++
 tb/tb_mat_skew_feeder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mat_skew_feeder.sv
// Skew feeder for the systolic MatUnit array: buffers row vectors and emits them as a diagonal wavefront.
// Optional macro MAT_SKEW_BUBBLE_CNT_EN adds a saturating underflow-bubble counter output.
module mat_skew_feeder #(
    parameter int WIDTH  = 128,
    parameter int FPSIZE = 16,
    parameter int DEPTH  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WIDTH-1:0][FPSIZE-1:0]  in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [WIDTH-1:0][FPSIZE-1:0]  skew_data,
    output logic [WIDTH-1:0]              skew_valid,
    output logic                          batch_done,
    output logic                          busy
`ifdef MAT_SKEW_BUBBLE_CNT_EN
    ,
    output logic [31:0]                   bubble_count
`endif
);

    // state   | meaning
    // IDLE    | no batch in progress; a pop starts one
    // STREAM  | batch open; pops every cycle, bubbles when FIFO empty
    // DRAIN   | last vector issued; no pops until its wavefront leaves
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int DCNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0][FPSIZE-1:0] mem_data_q [DEPTH];
    logic                         mem_last_q [DEPTH];
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;

    logic [1:0]                   state_q, state_d;
    logic [DCNT_W-1:0]            drain_cnt_q, drain_cnt_d;
    logic                         done_q, done_d;

    logic                         push;
    logic                         pop;
    logic [WIDTH-1:0][FPSIZE-1:0] pop_data;
    logic                         pop_last;

    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = (state_q != ST_DRAIN) & (count_q != '0);
    assign pop_data = mem_data_q[rd_ptr_q];
    assign pop_last = mem_last_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= in_data;
            mem_last_q[wr_ptr_q] <= in_last;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE, ST_STREAM: begin
                if (pop) begin
                    if (pop_last) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DCNT_W'(WIDTH - 1);
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q - 1'b1;
                // Leaving here lines done up with the last lane of the final vector.
                if (drain_cnt_q == DCNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
        end
    end

    assign batch_done = done_q;

    // Lane k is a chain of k+1 registers; non-pop cycles inject zero words.
    for (genvar k = 0; k < WIDTH; k++) begin : g_lane
        logic [k:0][FPSIZE-1:0] data_q;
        logic [k:0]             vld_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                data_q <= '0;
                vld_q  <= '0;
            end else begin
                data_q[0] <= pop ? pop_data[k] : '0;
                vld_q[0]  <= pop;
                for (int s = 1; s <= k; s++) begin
                    data_q[s] <= data_q[s-1];
                    vld_q[s]  <= vld_q[s-1];
                end
            end
        end

        assign skew_data[k]  = data_q[k];
        assign skew_valid[k] = vld_q[k];
    end

    assign busy = (count_q != '0) | (state_q != ST_IDLE) | (|skew_valid);

`ifdef MAT_SKEW_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((state_q == ST_STREAM) && (count_q == '0) && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_mat_skew_feeder.sv
// Bench for mat_skew_feeder (WIDTH=4): directed scenarios plus random traffic against a
// cycle-indexed pop-history reference model.
module tb_mat_skew_feeder;

    localparam int W    = 4;
    localparam int FP   = 16;
    localparam int D    = 4;
    localparam int NCYC = 4096;

    logic                  clock;
    logic                  reset;
    logic [W-1:0][FP-1:0]  in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic [W-1:0][FP-1:0]  skew_data;
    logic [W-1:0]          skew_valid;
    logic                  batch_done;
    logic                  busy;
`ifdef MAT_SKEW_BUBBLE_CNT_EN
    logic [31:0]           bubble_count;
`endif

    mat_skew_feeder #(.WIDTH(W), .FPSIZE(FP), .DEPTH(D)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .skew_data   (skew_data),
        .skew_valid  (skew_valid),
        .batch_done  (batch_done),
        .busy        (busy)
`ifdef MAT_SKEW_BUBBLE_CNT_EN
        ,
        .bubble_count(bubble_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO contents as queues, pop history indexed by cycle.
    logic [63:0] q_data[$];
    bit          q_last[$];
    bit          pop_flag [NCYC];
    logic [63:0] pop_dat  [NCYC];
    bit          pop_lst  [NCYC];
    int          next_ok;
    bit          in_batch;
    int          bubbles;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        q_data.delete();
        q_last.delete();
        for (int i = 0; i < NCYC; i++) begin
            pop_flag[i] = 1'b0;
            pop_dat[i]  = '0;
            pop_lst[i]  = 1'b0;
        end
        next_ok  = 0;
        in_batch = 1'b0;
        bubbles  = 0;
    endtask

    task automatic check_outputs();
        logic [63:0] ed;
        logic [W-1:0] ev;
        logic edone;
        int idx;
        ed = '0;
        ev = '0;
        for (int k = 0; k < W; k++) begin
            idx = cyc - 1 - k;
            if (idx >= 0 && pop_flag[idx]) begin
                ev[k] = 1'b1;
                ed[k*FP +: FP] = pop_dat[idx][k*FP +: FP];
            end
        end
        edone = (cyc >= W) && pop_flag[cyc-W] && pop_lst[cyc-W];
        check_eq("skew_data", skew_data, ed);
        check_eq("skew_valid", 64'(skew_valid), 64'(ev));
        check_eq("batch_done", 64'(batch_done), 64'(edone));
        check_eq("in_ready", 64'(in_ready), 64'(q_data.size() < D));
        check_eq("busy", 64'(busy),
                 64'((q_data.size() != 0) || in_batch || (cyc < next_ok) || (ev != '0)));
`ifdef MAT_SKEW_BUBBLE_CNT_EN
        check_eq("bubble_count", 64'(bubble_count), 64'(bubbles));
`endif
    endtask

    // One cycle: check outputs, drive inputs, advance model, move to next cycle.
    task automatic step(input logic v, input logic l, input logic [63:0] d, output bit acc);
        int sz;
        check_outputs();
        in_valid = v;
        in_last  = l;
        in_data  = d;
        sz  = q_data.size();
        acc = v && (sz < D);
        if (in_batch && sz == 0) bubbles++;
        if (sz > 0 && cyc >= next_ok) begin
            pop_flag[cyc] = 1'b1;
            pop_dat[cyc]  = q_data[0];
            pop_lst[cyc]  = q_last[0];
            if (q_last[0]) begin
                next_ok  = cyc + W;
                in_batch = 1'b0;
            end else begin
                in_batch = 1'b1;
            end
            void'(q_data.pop_front());
            void'(q_last.pop_front());
        end
        if (acc) begin
            q_data.push_back(d);
            q_last.push_back(l);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'h0, acc);
    endtask

    task automatic push_vec(input logic l, input logic [63:0] d);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) step(1'b1, l, d, acc);
        if (!acc) check_eq("push_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        model_clear();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #2;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_skew_valid", 64'(skew_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_batch_done", 64'(batch_done), 64'd0);
        @(posedge clock);
        #1;
        idle(3);

        // single-vector batch {4,3,2,1}
        push_vec(1'b1, {16'd4, 16'd3, 16'd2, 16'd1});
        idle(8);

        // one last vector, then six non-last vectors pushed during its drain
        push_vec(1'b1, 64'h1111_2222_3333_4444);
        for (int i = 0; i < 6; i++) push_vec(1'b0, {$urandom, $urandom});
        push_vec(1'b1, {$urandom, $urandom});
        idle(10);

        // 3-vector batch with a 2-cycle gap after vector 1
        push_vec(1'b0, {$urandom, $urandom});
        idle(2);
        push_vec(1'b0, {$urandom, $urandom});
        push_vec(1'b1, {$urandom, $urandom});
        idle(8);

        // two batches queued back-to-back
        push_vec(1'b0, {$urandom, $urandom});
        push_vec(1'b1, {$urandom, $urandom});
        push_vec(1'b1, {$urandom, $urandom});
        idle(12);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0),
                 {$urandom, $urandom}, acc);
        end
        in_valid = 1'b0;
        push_vec(1'b1, {$urandom, $urandom});
        idle(12);

        // reset while draining, with an extra vector buffered
        push_vec(1'b1, {$urandom, $urandom});
        step(1'b1, 1'b0, {$urandom, $urandom}, acc);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_skew_data", skew_data, 64'd0);
        check_eq("mid_rst_skew_valid", 64'(skew_valid), 64'd0);
        check_eq("mid_rst_batch_done", 64'(batch_done), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        model_clear();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
